alu_seq: RTL
============

Name: alu_seq

Overview:
- Parametrised, handshaked successor to the single-cycle datapath ALU. Width is set by WIDTH.
- Adds multi-cycle decimal (BCD) add/subtract that processes one nibble per cycle.
- Sits between the operand latches and the flag/result registers.
- Binary ops complete in one cycle. Decimal ops take WIDTH/4 further cycles.

Parameters:
- WIDTH, 8, datapath width in bits. Must be a multiple of 4 and at least 4. Nibble count N = WIDTH/4.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request (operands) presented
- req_ready  out  1  block can accept a request; high only in IDLE
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- op  in  4  operation code
- c_in  in  1  carry in (subtract: 1 means no borrow)
- bcd  in  1  decimal mode for op 2/3
- rsp_valid  out  1  result and flags valid
- rsp_ready  in  1  consumer accepts result
- y  out  WIDTH  result
- zero  out  1  y == 0
- negative  out  1  y[WIDTH-1]; op 9: a[WIDTH-1]
- overflow  out  1  signed overflow; op 9: a[WIDTH-2]
- c_out  out  1  carry out

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous, active-high.
- While reset is asserted: state=IDLE, y=0, zero=0, negative=0, overflow=0, c_out=0, rsp_valid=0. req_ready follows state, so it reads 1, but no acceptance occurs while reset is asserted.
- Reset mid-operation aborts immediately. All partial results are discarded.
- States:
  - IDLE: req_ready=1.
  - DADJ: decimal adjust; nibble index k and decimal carry registers.
  - DONE: rsp_valid=1.
- Accept: req_valid && req_ready at edge E0. Operands, op, c_in and bcd are latched.
- Non-decimal op: result and flags are registered at E0; state goes to DONE. rsp_valid is high after E0 (latency 1).
- Decimal op (bcd=1 and op 2 or 3): at E0 state goes to DADJ, with k=0, carry=c_in and binary overflow captured. At edges E1..EN, nibble k is processed and k increments. After EN state goes to DONE (latency N+1).
- Decimal add, per nibble: s = a_k + b_k + carry. If s > 9: s += 6 and carry=1, else carry=0. Store s[3:0].
- Decimal subtract, per nibble: d = b_k - a_k - (1-carry). If d < 0: d += 10 and carry=0, else carry=1. Store d[3:0].
- Decimal results: c_out = final carry. zero and negative come from the final y. overflow = binary-path overflow.
- Digits above 9 are not checked; the result follows the algorithm above.
- DONE: all outputs hold stable until rsp_ready=1. At that edge state goes to IDLE and rsp_valid drops.
- req_ready=0 in DADJ and DONE. Requests are not pipelined; there is no accept-on-release in the same cycle.
- Binary ops (all WIDTH wide):
  - 0 inc: {c_out,y} = a + c_in
  - 1 dec: {c_out,y} = a - c_in; c_out=1 on underflow
  - 2 add: {c_out,y} = a + b + c_in
  - 3 sub: {c_out,y} = ~a + b + c_in
  - 4 ror: y = {c_in, a[WIDTH-1:1]}, c_out = a[0]
  - 5 asl: {c_out,y} = {a, 0}
  - 6 rol: {c_out,y} = {a, c_in}
  - 7 or: y = a|b, c_out=0
  - 8 and: y = a&b, c_out=0
  - 9 bit test: y = a&b, c_out=0
  - a eor: y = a^b, c_out=0
  - b ones: y = all ones, c_out=1
  - others: y=0, c_out=0
- overflow (ops 2/3): carry into MSB xor carry out of MSB. All other ops: 0, except op 9.
- zero = (y==0) for every op.

Optional Feature:
- Macro: ALU_BCD_EN.
- Defined: DADJ state and decimal path are present, as described above.
- Undefined: bcd is ignored, ops 2/3 are always binary, the DADJ state is not built, and every op has latency 1.

Test Plan:
- WIDTH=8, op 2, a=0x50, b=0x50, c_in=0, bcd=0 -> after 1 edge: y=0xA0, negative=1, overflow=1, c_out=0, zero=0.
- WIDTH=8, ALU_BCD_EN, op 2, bcd=1, a=0x58, b=0x46, c_in=1 -> rsp_valid after 3 edges: y=0x05, c_out=1, req_ready=0 throughout.
- WIDTH=8, ALU_BCD_EN, op 3, bcd=1, a=0x12, b=0x40, c_in=1 -> y=0x28, c_out=1, zero=0, latency 3.
- Hold rsp_ready=0 for 5 cycles after a result, with req_valid=1 and new operands -> y and flags stable, rsp_valid=1, req_ready=0, no new accept. Raise rsp_ready -> IDLE on the next edge.
- Assert reset one cycle into DADJ -> immediately y=0, rsp_valid=0, all flags 0, state IDLE. After release, the next request computes correctly.
- WIDTH=16, op 4, a=0x0001, c_in=1 -> y=0x8000, c_out=1, negative=1. Then op 9, a=0xC000, b=0 -> y=0, zero=1, negative=1, overflow=1.

Source files
------------

// File: rtl/alu_seq.sv
// Handshaked ALU; binary ops take one cycle, BCD add/sub take WIDTH/4 more.
// Build with ALU_BCD_EN defined to include the decimal-adjust path.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  input  logic             c_in,
  input  logic             bcd,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             negative,
  output logic             overflow,
  output logic             c_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
`ifdef ALU_BCD_EN
    DADJ = 2'd1,
`endif
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] y_q;
  logic             z_q, n_q, v_q, c_q;
  logic             acc;
  logic             dec_req;

  logic [WIDTH-1:0] bin_y;
  logic             bin_c, bin_n, bin_v;
  logic [WIDTH-1:0] addx_a;
  logic [WIDTH:0]   addx;

  assign acc = req_valid && (state_q == IDLE);

  // ops 2/3 share one adder; sub feeds ~a
  always_comb begin
    addx_a = (op == 4'h3) ? ~a : a;
    addx   = {1'b0, addx_a} + {1'b0, b} + {{WIDTH{1'b0}}, c_in};
    bin_y  = '0;
    bin_c  = 1'b0;
    bin_v  = 1'b0;
    case (op)
      4'h0: {bin_c, bin_y} = {1'b0, a} + {{WIDTH{1'b0}}, c_in};
      4'h1: {bin_c, bin_y} = {1'b0, a} - {{WIDTH{1'b0}}, c_in};
      4'h2, 4'h3: begin
        {bin_c, bin_y} = addx;
        bin_v = addx[WIDTH] ^ (addx[WIDTH-1] ^ addx_a[WIDTH-1] ^ b[WIDTH-1]);
      end
      4'h4: {bin_c, bin_y} = {a[0], c_in, a[WIDTH-1:1]};
      4'h5: {bin_c, bin_y} = {a, 1'b0};
      4'h6: {bin_c, bin_y} = {a, c_in};
      4'h7: bin_y = a | b;
      4'h8: bin_y = a & b;
      4'h9: begin
        bin_y = a & b;
        bin_v = a[WIDTH-2];
      end
      4'ha: bin_y = a ^ b;
      4'hb: {bin_c, bin_y} = {1'b1, {WIDTH{1'b1}}};
      default: ;
    endcase
    bin_n = (op == 4'h9) ? a[WIDTH-1] : bin_y[WIDTH-1];
  end

`ifdef ALU_BCD_EN
  localparam int N  = WIDTH / 4;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  logic [WIDTH-1:0] da_q, db_q, ynext;
  logic             dsub_q, dc_q, dcn, last;
  logic [KW-1:0]    k_q;
  logic [4:0]       s5;
  logic [3:0]       nib;

  assign dec_req = bcd && (op == 4'h2 || op == 4'h3);
  assign last    = (k_q == KW'(N - 1));

  // one nibble per cycle; result shifts in from the top
  always_comb begin
    nib = '0;
    dcn = 1'b0;
    if (dsub_q) begin
      s5  = {1'b0, db_q[3:0]} - {1'b0, da_q[3:0]} - {4'b0, ~dc_q};
      dcn = ~s5[4];
      nib = s5[4] ? (s5[3:0] + 4'd10) : s5[3:0];
    end else begin
      s5  = {1'b0, da_q[3:0]} + {1'b0, db_q[3:0]} + {4'b0, dc_q};
      dcn = (s5 > 5'd9);
      nib = dcn ? (s5[3:0] + 4'd6) : s5[3:0];
    end
    ynext = (y_q >> 4) | (WIDTH'(nib) << (WIDTH - 4));
  end
`else
  logic unused_bcd;
  assign unused_bcd = bcd;
  assign dec_req    = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
`ifdef ALU_BCD_EN
        if (req_valid) state_d = dec_req ? DADJ : DONE;
`else
        if (req_valid) state_d = DONE;
`endif
      end
`ifdef ALU_BCD_EN
      DADJ: if (last) state_d = DONE;
`endif
      DONE: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == IDLE);
    rsp_valid = (state_q == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      y_q <= '0;
      z_q <= 1'b0;
      n_q <= 1'b0;
      v_q <= 1'b0;
      c_q <= 1'b0;
`ifdef ALU_BCD_EN
      da_q   <= '0;
      db_q   <= '0;
      dsub_q <= 1'b0;
      dc_q   <= 1'b0;
      k_q    <= '0;
`endif
    end else if (acc) begin
      v_q <= bin_v;
      if (dec_req) begin
        y_q <= '0;
        z_q <= 1'b0;
        n_q <= 1'b0;
        c_q <= 1'b0;
`ifdef ALU_BCD_EN
        da_q   <= a;
        db_q   <= b;
        dsub_q <= (op == 4'h3);
        dc_q   <= c_in;
        k_q    <= '0;
`endif
      end else begin
        y_q <= bin_y;
        z_q <= (bin_y == '0);
        n_q <= bin_n;
        c_q <= bin_c;
      end
`ifdef ALU_BCD_EN
    end else if (state_q == DADJ) begin
      y_q  <= ynext;
      da_q <= da_q >> 4;
      db_q <= db_q >> 4;
      dc_q <= dcn;
      k_q  <= k_q + 1'b1;
      if (last) begin
        z_q <= (ynext == '0);
        n_q <= ynext[WIDTH-1];
        c_q <= dcn;
      end
`endif
    end
  end

  assign y        = y_q;
  assign zero     = z_q;
  assign negative = n_q;
  assign overflow = v_q;
  assign c_out    = c_q;

endmodule
